// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and helpers for the sequential binary-to-BCD converter.
//   state_t      : converter FSM state (IDLE / SHIFT)
//   BCD_NIBBLE_W : width of one packed BCD digit
//   bcd_max()    : largest value representable in N decimal digits (10^N-1)
//   clog2()      : ceiling log2, used to size the step counter
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

  localparam int BCD_NIBBLE_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_if
// Start/busy/done bus between a producer and the bin2bcd_seq converter.
//   start : producer requests a conversion of bin (sampled only when idle)
//   bin   : unsigned binary value, captured on the accepting edge
//   busy  : converter is mid-conversion; start is ignored while high
//   done  : one-cycle pulse, bcd/ovf/blank updated in that same cycle
//   bcd   : packed BCD result, digit 0 in bcd[3:0], held until next done
//   ovf   : last captured value did not fit in DIGITS decimal digits
//   blank : per-digit leading-zero blank mask
// Handshake: a transfer happens on a rising edge where start=1 and the
// converter is idle (busy=0). The cycle carrying done=1 is idle, so a start
// present there is accepted on the following edge. No queueing: a start seen
// while busy=1 is dropped.
// Modports: master = producer, slave = converter.
// -----------------------------------------------------------------------------
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);

  logic                           start;
  logic [BIN_W-1:0]               bin;
  logic                           busy;
  logic                           done;
  logic [BCD_NIBBLE_W*DIGITS-1:0] bcd;
  logic                           ovf;
  logic [DIGITS-1:0]              blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, blank
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
//   din_i  : 4-bit working digit
//   dout_o : corrected digit (combinational)
// -----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  assign dout_o = (din_i >= 4'd5) ? (din_i + 4'd3) : din_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one shift step per clock, BIN_W steps
// per conversion, result presented as DIGITS packed BCD nibbles.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : bin2bcd_seq_if.slave (start/bin in, busy/done/bcd/ovf/blank out)
//   state_o : current FSM state, for observation
// Optional feature macro: BIN2BCD_BLANK_EN
//   defined   : blank marks digits above the most significant non-zero digit
//               (digit 0 never blanked, all zeros on overflow)
//   undefined : blank is constant zero
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic   clk,
  input  logic   reset_n,
  bin2bcd_seq_if.slave bus,
  output state_t state_o
);

  // One guard digit above the presented digits keeps overflowing inputs from
  // wrapping inside the working register during the shift steps.
  localparam int                WORK_W    = BCD_NIBBLE_W * (DIGITS + 1);
  localparam int                OUT_W     = BCD_NIBBLE_W * DIGITS;
  localparam int                CNT_W     = clog2(BIN_W + 1);
  localparam logic [63:0]       BCD_MAX   = bcd_max(DIGITS);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(BIN_W - 1);

  state_t           state_q;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [WORK_W-1:0] work_q, work_d, adj;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_next_q;
  logic             busy_q, done_q, ovf_q;
  logic [OUT_W-1:0] bcd_q;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din_i  (work_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .dout_o (adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Correct then shift the concatenated {working, shifter} pair by one bit.
  always_comb begin
    {work_d, shift_d} = {adj, shift_q} << 1;
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zeros_above;

  // Walk from the top digit down; a digit is blanked while every digit from
  // it upward is zero. Digit 0 is left out so a zero result still shows "0".
  always_comb begin
    blank_d     = '0;
    zeros_above = 1'b1;
    if (!ovf_next_q) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zeros_above = zeros_above & (work_d[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] == 4'd0);
        blank_d[i]  = zeros_above;
      end
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shift_q    <= bus.bin;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_next_q <= (64'(bus.bin) > BCD_MAX);
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work_q  <= work_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 1'b1;
          // The last step's shifted value is the final result; load it on
          // the same edge so done lands exactly BIN_W edges after accept.
          if (cnt_q == LAST_STEP) begin
            bcd_q   <= ovf_next_q ? {DIGITS{4'h9}} : work_d[OUT_W-1:0];
            ovf_q   <= ovf_next_q;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= blank_d;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq (BIN_W=20, DIGITS=6). Expected BCD, overflow
// and blank masks are hand-computed constants; blank expectations collapse to
// zero when BIN2BCD_BLANK_EN is not defined.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;

  logic   clk;
  logic   reset_n;
  state_t state_o;

  int vectors     = 0;
  int miscompares = 0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DIGITS-1:0] exp_blank(input logic [DIGITS-1:0] mask_en);
`ifdef BIN2BCD_BLANK_EN
    return mask_en;
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents start for exactly one edge; returns just after the accepting edge.
  task automatic do_start(input logic [BIN_W-1:0] v);
    bus.bin   = v;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen (lat = -1 on timeout) and how many of
  // the preceding samples had busy high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat, bc;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    vectors++; if (bus.bcd !== 24'h000000) begin miscompares++; $display("FAIL rst_bcd: got %h expected 000000", bus.bcd); end
    vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf); end
    vectors++; if (bus.blank !== 6'b000000) begin miscompares++; $display("FAIL rst_blank: got %b expected 000000", bus.blank); end
    vectors++; if (state_o !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d expected %0d", state_o, ST_IDLE); end

    do_start(20'd0);
    vectors++; if (state_o !== ST_SHIFT) begin miscompares++; $display("FAIL zero_state: got %0d expected %0d", state_o, ST_SHIFT); end
    wait_done(lat, bc);
    vectors++; if (lat !== 20) begin miscompares++; $display("FAIL zero_latency: got %0d expected 20", lat); end
    vectors++; if (bus.bcd !== 24'h000000) begin miscompares++; $display("FAIL zero_bcd: got %h expected 000000", bus.bcd); end
    vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL zero_ovf: got %b expected 0", bus.ovf); end
    vectors++; if (bus.blank !== exp_blank(6'b111110)) begin miscompares++; $display("FAIL zero_blank: got %b expected %b", bus.blank, exp_blank(6'b111110)); end
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    do_start(20'd4660);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_start: got %b expected 1", bus.busy); end
    wait_done(lat, bc);
    vectors++; if (lat !== 20) begin miscompares++; $display("FAIL basic_latency: got %0d expected 20", lat); end
    vectors++; if (bc !== 19) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 19", bc); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
    vectors++; if (bus.bcd !== 24'h004660) begin miscompares++; $display("FAIL basic_bcd: got %h expected 004660", bus.bcd); end
    vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b expected 0", bus.ovf); end
    vectors++; if (bus.blank !== exp_blank(6'b110000)) begin miscompares++; $display("FAIL basic_blank: got %b expected %b", bus.blank, exp_blank(6'b110000)); end
    step();
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    vectors++; if (bus.bcd !== 24'h004660) begin miscompares++; $display("FAIL basic_bcd_hold: got %h expected 004660", bus.bcd); end
  endtask

  task automatic test_limits();
    int lat, bc;
    do_start(20'd999999);
    wait_done(lat, bc);
    vectors++; if (bus.bcd !== 24'h999999) begin miscompares++; $display("FAIL max_bcd: got %h expected 999999", bus.bcd); end
    vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL max_ovf: got %b expected 0", bus.ovf); end
    vectors++; if (bus.blank !== 6'b000000) begin miscompares++; $display("FAIL max_blank: got %b expected 000000", bus.blank); end
    step();

    do_start(20'd1000000);
    wait_done(lat, bc);
    vectors++; if (lat !== 20) begin miscompares++; $display("FAIL ovf_latency: got %0d expected 20", lat); end
    vectors++; if (bus.bcd !== 24'h999999) begin miscompares++; $display("FAIL ovf_bcd: got %h expected 999999", bus.bcd); end
    vectors++; if (bus.ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", bus.ovf); end
    vectors++; if (bus.blank !== 6'b000000) begin miscompares++; $display("FAIL ovf_blank: got %b expected 000000", bus.blank); end
    step();

    do_start(20'hFFFFF);
    wait_done(lat, bc);
    vectors++; if (bus.bcd !== 24'h999999) begin miscompares++; $display("FAIL allones_bcd: got %h expected 999999", bus.bcd); end
    vectors++; if (bus.ovf !== 1'b1) begin miscompares++; $display("FAIL allones_ovf: got %b expected 1", bus.ovf); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bc, first_done;
    first_done = -1;
    do_start(20'd1234);
    for (int n = 1; n <= 20; n++) begin
      if (n == 5 || n == 10 || n == 20) begin
        bus.start = 1'b1;
        bus.bin   = 20'd777;
      end else begin
        bus.start = 1'b0;
      end
      step();
      if (bus.done === 1'b1 && first_done < 0) first_done = n;
    end
    vectors++; if (first_done !== 20) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 20", first_done); end
    vectors++; if (bus.bcd !== 24'h001234) begin miscompares++; $display("FAIL b2b_first_bcd: got %h expected 001234", bus.bcd); end
    vectors++; if (bus.blank !== exp_blank(6'b110000)) begin miscompares++; $display("FAIL b2b_first_blank: got %b expected %b", bus.blank, exp_blank(6'b110000)); end

    // start still high through the done cycle: accepted on this edge
    step();
    bus.start = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_busy: got %b expected 1", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.done); end
    wait_done(lat, bc);
    vectors++; if (lat + 1 !== 21) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 21", lat + 1); end
    vectors++; if (bus.bcd !== 24'h000777) begin miscompares++; $display("FAIL b2b_second_bcd: got %h expected 000777", bus.bcd); end
    vectors++; if (bus.blank !== exp_blank(6'b111000)) begin miscompares++; $display("FAIL b2b_second_blank: got %b expected %b", bus.blank, exp_blank(6'b111000)); end
    step();
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses;
    pulses = 0;
    do_start(20'd98765);
    repeat (8) step();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    vectors++; if (bus.bcd !== 24'h000000) begin miscompares++; $display("FAIL abort_bcd: got %h expected 000000", bus.bcd); end
    vectors++; if (state_o !== ST_IDLE) begin miscompares++; $display("FAIL abort_state: got %0d expected %0d", state_o, ST_IDLE); end
    step();
    reset_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", pulses); end
    vectors++; if (bus.bcd !== 24'h000000) begin miscompares++; $display("FAIL abort_bcd_idle: got %h expected 000000", bus.bcd); end

    do_start(20'd42);
    wait_done(lat, bc);
    vectors++; if (lat !== 20) begin miscompares++; $display("FAIL after_abort_latency: got %0d expected 20", lat); end
    vectors++; if (bus.bcd !== 24'h000042) begin miscompares++; $display("FAIL after_abort_bcd: got %h expected 000042", bus.bcd); end
    vectors++; if (bus.blank !== exp_blank(6'b111100)) begin miscompares++; $display("FAIL after_abort_blank: got %b expected %b", bus.blank, exp_blank(6'b111100)); end
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    test_reset();
    test_basic();
    test_limits();
    test_back_to_back();
    test_reset_abort();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
